rvv_backend_alu_issue: RTL

RVV_BACKEND_ALU_ISSUE -- requirements
Module: rvv_backend_alu_issue

---
 rtl/rvv_backend_alu_issue.sv | 110 +++++++++++
 1 files changed

// File: rtl/rvv_backend_alu_issue.sv
// Issue stage between the ALU reservation station and two ALU lanes.
// Pops up to two uops per cycle into free lanes and counts stalled cycles.
`ifndef ALU_RS_WIDTH
`define ALU_RS_WIDTH 128
`endif

module rvv_backend_alu_issue #(
  parameter int DWIDTH = `ALU_RS_WIDTH,
  parameter int CNTW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0][DWIDTH-1:0] alu_uop_rs2ex,
  input  logic                   fifo_empty_rs2ex,
  input  logic                   fifo_1left_to_empty_rs2ex,
  output logic [1:0]             pop_ex2rs,
  input  logic                   trap_flush_rvv,
  output logic [1:0]             uop_valid_ex,
  output logic [1:0][DWIDTH-1:0] uop_data_ex,
  input  logic [1:0]             uop_ready_ex,
  output logic [CNTW-1:0]        stall_cnt
);

  logic [1:0] free;
  logic       has1;
  logic       has2;
  logic       both_free;
  logic       load0;
  logic       load1;
  logic       sel1;
  logic [1:0] valid_n;
  logic       stall_inc;

  assign free      = ~uop_valid_ex | uop_ready_ex;
  assign both_free = &free;
  assign has1      = ~fifo_empty_rs2ex;
  assign has2      = ~fifo_empty_rs2ex & ~fifo_1left_to_empty_rs2ex;

  // sel1 picks the second-oldest entry for lane1 only on a dual pop
  always_comb begin
    pop_ex2rs = 2'b00;
    load0     = 1'b0;
    load1     = 1'b0;
    sel1      = 1'b0;
    if (rst_n && !trap_flush_rvv && has1) begin
      unique case (1'b1)
        both_free && has2: begin
          pop_ex2rs = 2'b11;
          load0     = 1'b1;
          load1     = 1'b1;
          sel1      = 1'b1;
        end
        both_free && !has2: begin
          pop_ex2rs = 2'b01;
          load0     = 1'b1;
        end
        free == 2'b01: begin
          pop_ex2rs = 2'b01;
          load0     = 1'b1;
        end
        free == 2'b10: begin
          pop_ex2rs = 2'b01;
          load1     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_n = uop_valid_ex;
    if (trap_flush_rvv) begin
      valid_n = 2'b00;
    end else begin
      if (load0)        valid_n[0] = 1'b1;
      else if (free[0]) valid_n[0] = 1'b0;
      if (load1)        valid_n[1] = 1'b1;
      else if (free[1]) valid_n[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uop_valid_ex <= 2'b00;
    end else begin
      uop_valid_ex <= valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uop_data_ex <= '0;
    end else begin
      if (load0) uop_data_ex[0] <= alu_uop_rs2ex[0];
      if (load1) uop_data_ex[1] <= sel1 ? alu_uop_rs2ex[1]
                                        : alu_uop_rs2ex[0];
    end
  end

  assign stall_inc = has1 && (pop_ex2rs == 2'b00) && !trap_flush_rvv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_inc && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule
